// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and width helpers for the round-robin arbiter that owns
// the shared q/q_bar storage register.
package dff_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Width of an index/counter able to represent 0..n-1, never below one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared register arbiter: requests, write data,
// clear, grants and the q/q_bar storage outputs.
interface dff_bank_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned OW = dff_arb_pkg::clog2_min1(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic                  clr;
    logic [NREQ-1:0]       gnt;
    logic [OW-1:0]         owner;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      q_bar;

    modport master (
        output req, wdata, clr,
        input  gnt, owner, busy, q, q_bar
    );

    modport slave (
        input  req, wdata, clr,
        output gnt, owner, busy, q, q_bar
    );

endinterface

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request scanning upward from
// ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = dff_arb_pkg::clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            valid
);

    always_comb begin
        int unsigned idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            // Explicit wrap keeps non-power-of-2 NREQ correct.
            idx = 32'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit q/q_bar storage register among
// NREQ requesters, with a per-tenure write limit of MAX_HOLD cycles.
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    dff_bank_arbiter_if.slave bus
);

    localparam int unsigned   OW        = clog2_min1(NREQ);
    localparam int unsigned   HW        = clog2_min1(MAX_HOLD + 1);
    localparam logic [OW-1:0] LAST_IDX  = OW'(NREQ - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_bar_q, q_bar_d;

    logic [OW-1:0]    winner;
    logic             win_valid;
    logic [WIDTH-1:0] owner_data;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (OW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .valid  (win_valid)
    );

    assign owner_data = bus.wdata[32'(owner_q)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            q_q        <= '0;
            q_bar_q    <= '1;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            q_q        <= q_d;
            q_bar_q    <= q_bar_d;
        end
    end

    always_comb begin
        logic do_write;
        logic release_now;
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        q_d         = q_q;
        q_bar_d     = q_bar_q;
        do_write    = 1'b0;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d        = BUSY;
                    gnt_d          = '0;
                    gnt_d[winner]  = 1'b1;
                    owner_d        = winner;
                    hold_cnt_d     = '0;
                end
            end
            BUSY: begin
                if (bus.req[owner_q]) begin
                    do_write    = 1'b1;
                    hold_cnt_d  = hold_cnt_q + 1'b1;
                    release_now = (hold_cnt_q == HOLD_LAST);
                end else begin
                    release_now = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (release_now) begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
            ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end

        // clr wins over the write but the tenure bookkeeping above still advances.
        if (bus.clr) begin
            q_d     = '0;
            q_bar_d = '1;
        end else if (do_write) begin
            q_d     = owner_data;
            q_bar_d = ~owner_data;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q == BUSY);
    assign bus.q     = q_q;
    assign bus.q_bar = q_bar_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scenario bench for dff_bank_arbiter: expected register writes are queued
// when stimulus is driven and compared when the write edge has passed.
module tb_dff_bank_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [7:0] sb[$];

    dff_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    dff_bank_arbiter #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.wdata[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.clr = 1'b0;
        bus.wdata = '0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] e;
        rst = 1'b1;
        bus.req = '0;
        bus.clr = 1'b0;
        bus.wdata = '0;
        #2;
        tests++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0 ||
            bus.q !== 8'h00 || bus.q_bar !== 8'hFF) begin
            fails++;
            $display("FAIL reset_init: gnt=%b busy=%b owner=%0d q=%h q_bar=%h want 0000 0 0 00 ff",
                     bus.gnt, bus.busy, bus.owner, bus.q, bus.q_bar);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus.req = 4'b0001;
        set_data(0, 8'h3C);
        tick();
        sb.push_back(8'h3C);
        tick();
        e = sb.pop_front();
        tests++;
        if (bus.q !== e || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_prewrite: q=%h busy=%b want %h 1", bus.q, bus.busy, e);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.owner !== 2'd0 ||
            bus.q !== 8'h00 || bus.q_bar !== 8'hFF) begin
            fails++;
            $display("FAIL reset_async: gnt=%b busy=%b owner=%0d q=%h q_bar=%h want 0000 0 0 00 ff",
                     bus.gnt, bus.busy, bus.owner, bus.q, bus.q_bar);
        end
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] e;
        do_reset();
        bus.req = 4'b0100;
        set_data(2, 8'hA5);
        tick();
        tests++;
        if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2 || bus.busy !== 1'b1 || bus.q !== 8'h00) begin
            fails++;
            $display("FAIL single_grant: gnt=%b owner=%0d busy=%b q=%h want 0100 2 1 00",
                     bus.gnt, bus.owner, bus.busy, bus.q);
        end
        sb.push_back(8'hA5);
        tick();
        e = sb.pop_front();
        tests++;
        if (bus.q !== e || bus.q_bar !== ~e) begin
            fails++;
            $display("FAIL single_write: q=%h q_bar=%h want %h %h", bus.q, bus.q_bar, e, ~e);
        end
        bus.req = 4'b0000;
        tick();
        tests++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.q !== 8'hA5) begin
            fails++;
            $display("FAIL single_release: gnt=%b busy=%b q=%h want 0000 0 a5",
                     bus.gnt, bus.busy, bus.q);
        end
        bus.req = 4'b1111;
        tick();
        tests++;
        if (bus.owner !== 2'd3 || bus.gnt !== 4'b1000) begin
            fails++;
            $display("FAIL single_ptr: owner=%0d gnt=%b want 3 1000", bus.owner, bus.gnt);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_hold_limit();
        logic [7:0] e;
        do_reset();
        bus.req = 4'b0010;
        set_data(1, 8'h10);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_data(1, 8'h10 + 8'(k));
            sb.push_back(8'h10 + 8'(k));
            tick();
            e = sb.pop_front();
            tests++;
            if (bus.q !== e || bus.q_bar !== ~e) begin
                fails++;
                $display("FAIL hold_write%0d: q=%h q_bar=%h want %h %h", k, bus.q, bus.q_bar, e, ~e);
            end
        end
        tests++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: gnt=%b busy=%b want 0000 0", bus.gnt, bus.busy);
        end
        set_data(1, 8'h14);
        tick();
        tests++;
        if (bus.gnt !== 4'b0010 || bus.q !== 8'h13) begin
            fails++;
            $display("FAIL hold_regrant: gnt=%b q=%h want 0010 13", bus.gnt, bus.q);
        end
        set_data(1, 8'h15);
        sb.push_back(8'h15);
        tick();
        e = sb.pop_front();
        tests++;
        if (bus.q !== e) begin
            fails++;
            $display("FAIL hold_newtenure: q=%h want %h", bus.q, e);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_fairness();
        logic [7:0] e;
        int prev;
        int exp_owner;
        do_reset();
        for (int i = 0; i < 4; i++) set_data(i, 8'h40 + 8'(i));
        bus.req = 4'b1111;
        prev = -1;
        for (int t = 0; t < 5; t++) begin
            exp_owner = t % 4;
            tick();
            tests++;
            if (int'(bus.owner) !== exp_owner || bus.gnt !== (4'b0001 << exp_owner) ||
                int'(bus.owner) == prev) begin
                fails++;
                $display("FAIL fair_grant%0d: owner=%0d gnt=%b want %0d onehot", t, bus.owner, bus.gnt, exp_owner);
            end
            prev = int'(bus.owner);
            for (int w = 0; w < 4; w++) begin
                sb.push_back(8'h40 + 8'(exp_owner));
                tick();
                e = sb.pop_front();
                tests++;
                if (bus.q !== e || bus.busy !== (w < 3)) begin
                    fails++;
                    $display("FAIL fair_write%0d_%0d: q=%h busy=%b want %h %b", t, w, bus.q, bus.busy, e, w < 3);
                end
            end
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_early_drop_wrap();
        logic [7:0] e;
        do_reset();
        bus.req = 4'b1000;
        set_data(3, 8'h33);
        set_data(2, 8'h22);
        set_data(0, 8'h99);
        tick();
        bus.req = 4'b1101;
        for (int w = 0; w < 2; w++) begin
            sb.push_back(8'h33);
            tick();
            e = sb.pop_front();
            tests++;
            if (bus.q !== e || bus.owner !== 2'd3) begin
                fails++;
                $display("FAIL drop_write%0d: q=%h owner=%0d want %h 3", w, bus.q, bus.owner, e);
            end
        end
        bus.req = 4'b0101;
        tick();
        tests++;
        if (bus.gnt !== 4'b0000 || bus.q !== 8'h33) begin
            fails++;
            $display("FAIL drop_release: gnt=%b q=%h want 0000 33", bus.gnt, bus.q);
        end
        tick();
        tests++;
        if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0) begin
            fails++;
            $display("FAIL drop_wrap: gnt=%b owner=%0d want 0001 0", bus.gnt, bus.owner);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_clr_collision();
        logic [7:0] e;
        do_reset();
        bus.req = 4'b0001;
        set_data(0, 8'h77);
        tick();
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        tests++;
        if (bus.q !== 8'h00 || bus.q_bar !== 8'hFF || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL clr_override: q=%h q_bar=%h busy=%b want 00 ff 1", bus.q, bus.q_bar, bus.busy);
        end
        for (int w = 0; w < 3; w++) begin
            sb.push_back(8'h77);
            tick();
            e = sb.pop_front();
            tests++;
            if (bus.q !== e || bus.q_bar !== ~e || bus.busy !== (w < 2)) begin
                fails++;
                $display("FAIL clr_after%0d: q=%h q_bar=%h busy=%b want %h %h %b",
                         w, bus.q, bus.q_bar, bus.busy, e, ~e, w < 2);
            end
        end
        bus.req = '0;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.req = '0;
        bus.clr = 1'b0;
        bus.wdata = '0;
        test_reset();
        test_single();
        test_hold_limit();
        test_fairness();
        test_early_drop_wrap();
        test_clr_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit D-flip-flop storage register (q / q_bar pair) between NREQ requesters.
- Each requester raises req, waits for its one-hot grant, then writes its data into the register every cycle while it holds req.
- A hold limit bounds each tenure so no requester can starve the others.
- Sits between several producer blocks and the shared flip-flop storage; q/q_bar feed downstream logic.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WIDTH, 8, width of the shared register and of each requester's data.
- MAX_HOLD, 4, maximum write cycles per grant tenure (>=1).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  request per requester; bit i is requester i.
- wdata  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
- clr  input  1  synchronous clear of the shared register.
- gnt  output  NREQ  registered one-hot grant; all-zero when idle.
- owner  output  $clog2(NREQ)  index of the current grant holder; 0 when idle.
- busy  output  1  high while a grant is held.
- q  output  WIDTH  shared register contents.
- q_bar  output  WIDTH  bitwise complement of q; updates on the same edge as q, never a cycle late.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, gnt=0, owner=0, busy=0, ptr=0, hold_cnt=0.
  - q=0, q_bar=all ones.
  - Reset mid-tenure aborts the tenure immediately; no write completes.
- State IDLE:
  - If req!=0, pick the winner: the first set req bit scanning ptr, ptr+1, ... modulo NREQ.
  - Next edge: gnt=onehot(winner), owner=winner, busy=1, hold_cnt=0, state=BUSY.
  - No write occurs in IDLE.
- State BUSY, with req[owner]=1:
  - Edge writes q<=wdata[owner] and q_bar<=~wdata[owner]; hold_cnt increments.
  - If hold_cnt==MAX_HOLD-1 at that edge, the write still happens and the block releases.
- State BUSY, with req[owner]=0:
  - No write; release.
- Release (one edge):
  - gnt=0, busy=0, owner=0, ptr=(owner+1) mod NREQ, state=IDLE.
  - This leaves exactly one idle cycle between tenures.
- Latency:
  - req rise in IDLE -> gnt on the next edge -> first write on the following edge.
  - Each tenure is at most MAX_HOLD write edges plus one release edge.
- Requests from non-owners during BUSY are ignored; they are arbitrated at the next IDLE.
- A req deassertion before the grant arrives simply loses the arbitration; nothing is latched.
- clr=1:
  - q<=0 and q_bar<=all ones on that edge, overriding any simultaneous write.
  - Arbitration state and hold_cnt advance as if the write had occurred, so the tenure is still consumed.
- Width rules:
  - hold_cnt is $clog2(MAX_HOLD+1) bits.
  - ptr and owner wrap modulo NREQ; for non-power-of-2 NREQ, explicitly wrap NREQ-1 -> 0.
- Invariants:
  - gnt is zero or one-hot.
  - busy==|gnt.
  - q_bar==~q on every cycle.

Decomposition:
- Package dff_arb_pkg: state enum (IDLE, BUSY); helper function for the clog2 width of owner/hold_cnt.
- Sub-module rr_pick: combinational round-robin priority selector.
  - Inputs: req, ptr.
  - Outputs: winner index, valid.
  - Reusable by other shared-resource arbiters in the codebase.

Test Plan:
- Reset: rst asserted mid-tenure while BUSY with q=0x3C -> gnt=0, busy=0, q=0x00, q_bar=0xFF immediately, without waiting for a clock edge.
- Single requester: req=4'b0100, wdata[2]=0xA5 from idle at ptr=0 -> edge1 gnt=0100, owner=2; edge2 q=0xA5, q_bar=0x5A. Then drop req -> next edge gnt=0, ptr=3.
- Hold limit: req[1] held with data incrementing 0x10..0x17, MAX_HOLD=4 -> exactly 4 writes (q ends at 0x13), forced release, gnt=0 for one cycle. Then requester 1 is re-granted only because it is the sole requester.
- Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0. Each tenure is 4 gnt cycles plus 1 idle cycle; there are never two consecutive tenures for the same requester.
- Early drop plus wrap: owner 3 drops req after 2 writes while req[0] and req[2] are pending -> release, then the next grant goes to 0 (ptr wrapped to 0), not 2.
- clr collision: clr=1 on the same edge as an owner write of 0x77 -> q=0x00, q_bar=0xFF, hold_cnt incremented. The next write of 0x77 lands normally.
